// File: rtl/if_id_pkg.sv
// if_id_pkg: shared types and default constants for the IF->ID skid register
package if_id_pkg;

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} if_id_state_t;

    localparam int INSTR_W_DEF = 12;
    localparam int PC_W_DEF    = 8;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = '0;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [PC_W_DEF-1:0]    pc;
    } if_id_entry_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one pipeline entry with load enable and synchronous clear to the bubble value
module pipe_entry_reg
    import if_id_pkg::*;
#(
    parameter int          W    = INSTR_W_DEF + PC_W_DEF,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // clear beats load so a redirect can never leave stale data behind
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q <= INIT;
        else if (clr)
            q <= INIT;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF->ID boundary register with valid/ready, one-entry skid, flush and stall counter
module if_id_skid_reg
    import if_id_pkg::*;
#(
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter int                 PC_W      = PC_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               stat_clr,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int            EW        = INSTR_W + PC_W;
    localparam logic [EW-1:0] NOP_ENTRY = {NOP_INSTR, {PC_W{1'b0}}};

    if_id_state_t  state, state_nxt;
    logic          accept, pop;
    logic          main_load, skid_load, main_from_skid;
    logic [EW-1:0] main_q, skid_q, main_d;

    assign in_ready  = (state != FULL) && !flush;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign main_d    = main_from_skid ? skid_q : {in_instr, in_pc};
    assign out_instr = out_valid ? main_q[EW-1:PC_W] : NOP_INSTR;
    assign out_pc    = out_valid ? main_q[PC_W-1:0] : '0;

    // occupancy state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // next occupancy and entry load strobes; flush overrides everything
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                state_nxt = BUSY;
                main_load = 1'b1;
            end
            BUSY: if (accept && pop) begin
                main_load = 1'b1;
            end else if (accept) begin
                state_nxt = FULL;
                skid_load = 1'b1;
            end else if (pop) begin
                state_nxt = EMPTY;
            end
            FULL: if (pop) begin
                state_nxt      = BUSY;
                main_load      = 1'b1;
                main_from_skid = 1'b1;
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush)
            state_nxt = EMPTY;
    end

    pipe_entry_reg #(.W(EW), .INIT(NOP_ENTRY)) u_main (
        .clk(clk), .reset_n(reset_n), .clr(flush), .load(main_load), .d(main_d), .q(main_q)
    );

    pipe_entry_reg #(.W(EW), .INIT(NOP_ENTRY)) u_skid (
        .clk(clk), .reset_n(reset_n), .clr(flush), .load(skid_load), .d({in_instr, in_pc}), .q(skid_q)
    );

    // saturating count of cycles where decode holds off a valid head
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (stat_clr)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: table vectors, corner sequences and random traffic against a queue model
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_instr = '0;
    logic [7:0]  in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_instr;
    logic [7:0]  out_pc;
    logic        stat_clr = 1'b0;
    logic [3:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [19:0] q[$];
    int          m_cnt = 0;

    typedef struct {
        logic        iv;
        logic [11:0] instr;
        logic        ordy;
        logic        e_ovalid;
        logic [11:0] e_oinstr;
        logic        e_iready;
        int          e_stall;
    } vec_t;

    vec_t vecs[$];

    if_id_skid_reg #(.INSTR_W(12), .PC_W(8), .NOP_INSTR(12'h000), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .stat_clr(stat_clr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_check();
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2 && !flush));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("out_instr", 32'(out_instr), q.size() > 0 ? 32'(q[0][19:8]) : 32'h0);
        chk("out_pc", 32'(out_pc), q.size() > 0 ? 32'(q[0][7:0]) : 32'h0);
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    endtask

    task automatic drive(logic iv, logic [11:0] ins, logic [7:0] p, logic ordy, logic fl, logic sc);
        in_valid = iv;
        in_instr = ins;
        in_pc = p;
        out_ready = ordy;
        flush = fl;
        stat_clr = sc;
        #1;
        model_check();
    endtask

    task automatic tick();
        logic        acc, pp;
        logic [19:0] e;
        acc = in_valid && q.size() < 2 && !flush;
        pp = q.size() > 0 && out_ready;
        e = {in_instr, in_pc};
        if (stat_clr)
            m_cnt = 0;
        else if (q.size() > 0 && !out_ready && m_cnt < 15)
            m_cnt++;
        @(posedge clk);
        if (pp)
            void'(q.pop_front());
        if (flush)
            q.delete();
        if (acc)
            q.push_back(e);
        @(negedge clk);
    endtask

    task automatic step(logic iv, logic [11:0] ins, logic [7:0] p, logic ordy, logic fl, logic sc);
        drive(iv, ins, p, ordy, fl, sc);
        tick();
    endtask

    task automatic add_vec(logic iv, logic [11:0] ins, logic ordy, logic ov, logic [11:0] oi, logic ir, int st);
        vec_t v;
        v.iv = iv; v.instr = ins; v.ordy = ordy;
        v.e_ovalid = ov; v.e_oinstr = oi; v.e_iready = ir; v.e_stall = st;
        vecs.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < 10; i++)
            add_vec(1'b1, 12'(i + 1), 1'b1, i > 0, i > 0 ? 12'(i) : 12'h0, 1'b1, 0);
        add_vec(1'b0, 12'h0,   1'b1, 1'b1, 12'h00A, 1'b1, 0);
        add_vec(1'b1, 12'h011, 1'b1, 1'b0, 12'h000, 1'b1, 0);
        add_vec(1'b1, 12'h022, 1'b0, 1'b1, 12'h011, 1'b1, 0);
        add_vec(1'b0, 12'h0,   1'b0, 1'b1, 12'h011, 1'b0, 1);
        add_vec(1'b0, 12'h0,   1'b0, 1'b1, 12'h011, 1'b0, 2);
        add_vec(1'b0, 12'h0,   1'b0, 1'b1, 12'h011, 1'b0, 3);
        add_vec(1'b0, 12'h0,   1'b1, 1'b1, 12'h011, 1'b0, 4);
        add_vec(1'b0, 12'h0,   1'b1, 1'b1, 12'h022, 1'b1, 4);
        add_vec(1'b0, 12'h0,   1'b1, 1'b0, 12'h000, 1'b1, 4);

        repeat (2) @(negedge clk);
        drive(1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].instr, 8'(vecs[i].instr + 12'h40), vecs[i].ordy, 1'b0, 1'b0);
            chk("vec_out_valid", 32'(out_valid), 32'(vecs[i].e_ovalid));
            chk("vec_out_instr", 32'(out_instr), 32'(vecs[i].e_oinstr));
            chk("vec_in_ready", 32'(in_ready), 32'(vecs[i].e_iready));
            chk("vec_stall_cnt", 32'(stall_cnt), 32'(vecs[i].e_stall));
            tick();
        end

        step(1'b1, 12'h0A1, 8'hA1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 12'h0A2, 8'hA2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 12'h0BB, 8'hBB, 1'b0, 1'b1, 1'b0);
        chk("flush_in_ready", 32'(in_ready), 32'h0);
        tick();
        drive(1'b0, 12'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        chk("flush_out_instr", 32'(out_instr), 32'h0);
        tick();
        step(1'b0, 12'h0, 8'h0, 1'b1, 1'b0, 1'b0);

        step(1'b1, 12'h055, 8'h55, 1'b0, 1'b0, 1'b1);
        repeat (20) step(1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'hF);
        tick();
        drive(1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        chk("clr_stall_cnt", 32'(stall_cnt), 32'h0);
        tick();
        drive(1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        chk("resume_stall_cnt", 32'(stall_cnt), 32'h1);
        tick();

        step(1'b1, 12'h0C1, 8'hC1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_full", 32'(in_ready), 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        q.delete();
        m_cnt = 0;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_out_instr", 32'(out_instr), 32'h0);
        chk("arst_out_pc", 32'(out_pc), 32'h0);
        chk("arst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 12'h3C0, 8'h3C, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 12'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_instr", 32'(out_instr), 32'h3C0);
        chk("post_rst_valid", 32'(out_valid), 32'h1);
        tick();

        for (int i = 0; i < 10000; i++)
            step(1'($urandom_range(0, 1)), 12'($urandom), 8'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
        repeat (3) step(1'b0, 12'h0, 8'h0, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
